ra_stack: RTL and testbench
===========================

Name: ra_stack

Overview:
- Hardware return-address stack that produces the `ra` operand consumed by the PC block's return path (pcSrc = return).
- Call instructions push the link address; return instructions pop it.
- Sits beside the PC block in the fetch stage. It is gated by the same write-enable as the PC, so stalls freeze both together.

Parameters:
- DEPTH, 8, number of 16-bit entries; must be a power of two, at least 2.
- PTR_W, 3, log2(DEPTH); width of the internal top pointer.
- ADDR_W, 16, width of stored return addresses.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rasWrite  input  1  stack update enable (driven with pcWrite); push/pop are ignored when 0.
- push  input  1  call: store pushAddr as the new top.
- pop  input  1  return: discard the top entry.
- pushAddr  input  ADDR_W  link address to push (PC of call + 2).
- ra  output  ADDR_W  current top-of-stack address; 0 when empty.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was lost or an entry was overwritten.
- underflow  output  1  sticky: a pop was attempted while empty.
- clearErr  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - count=0, top pointer=0, ra=0, empty=1, full=0, overflow=0, underflow=0.
  - Entry storage is not cleared.
- ra, empty, full and count are decoded from registered state only. There is no combinational path from push/pop/pushAddr to any output.
- Update latency: one cycle. Values are visible right after the rising edge that samples the operation.
- Operations apply only when rasWrite=1 (sampled at the edge). With rasWrite=0 all state holds, including when push/pop are asserted.
- Operation table at the edge (rasWrite=1):
  - push only, not full: entry[top+1]=pushAddr; top+1; count+1.
  - push only, full: see Optional Feature.
  - pop only, not empty: top−1; count−1.
  - pop only, empty: no state change; underflow set to 1.
  - push and pop, not empty: tail-call replace. entry[top]=pushAddr; top and count unchanged; no flag change even when full.
  - push and pop, empty: behaves as push only; count becomes 1; no underflow.
  - neither: hold.
- Pointer arithmetic is modulo DEPTH (PTR_W bits wrap naturally). count saturates at 0 and DEPTH.
- ra = entry[top] when count>0, else 0.
- Error flags:
  - overflow and underflow stay set until clearErr=1 or reset.
  - clearErr acts independently of rasWrite.
  - If clearErr coincides with a new error event, the event wins and the flag stays set.
- Reset asserted mid-operation aborts the pending update. Deassertion takes effect from the next edge.

Optional Feature:
- Macro: RAS_WRAP_EN.
- Defined (circular stack):
  - Push when full writes entry[top+1], overwriting the oldest entry.
  - top advances; count stays DEPTH; overflow set to 1.
  - Subsequent pops return the DEPTH newest addresses.
- Undefined (bounded stack):
  - Push when full is dropped: no entry written, top/count/ra unchanged.
  - overflow set to 1.

Test Plan:
- Reset, then hold rasWrite=1 with no operation -> ra=0, count=0, empty=1, overflow=0, underflow=0. Assert reset asynchronously between edges -> outputs return to these values before the next edge.
- Push 0x0010, 0x0020, 0x0030 on consecutive edges -> after each edge ra=0x0010/0x0020/0x0030, count=1/2/3. Then three pops -> ra=0x0020, 0x0010, 0x0000 with empty=1.
- Push 0x0100, then push=1 with rasWrite=0 and pushAddr=0x0200 for 3 cycles -> ra stays 0x0100, count=1. Then push+pop with pushAddr=0x0300 -> ra=0x0300, count=1.
- Pop when empty -> underflow=1, count=0. Pulse clearErr -> underflow=0. Pop and clearErr in the same cycle -> underflow=1.
- Push 0x0002..0x0010 step 2 (8 pushes, DEPTH=8) -> full=1, ra=0x0010. Push 0x0012:
  - RAS_WRAP_EN undefined: ra=0x0010, count=8, overflow=1.
  - RAS_WRAP_EN defined: ra=0x0012, count=8, overflow=1; 8 pops yield 0x0012 down to 0x0004.
- Random push/pop/rasWrite sequence (≥500 cycles) against a behavioural queue model -> ra, count and flags match every cycle.

Source files
------------

// File: rtl/ra_stack.sv
// ----------------------------------------------------------------------------
// ra_stack -- hardware return-address stack for the fetch stage.
//
// Call instructions push their link address and return instructions pop it.
// The top entry is presented on `ra` for the PC block's return path. The stack
// shares the PC write-enable, so a stall freezes both together.
//
// Optional build macro:
//   RAS_WRAP_EN  defined   -> circular stack. A push when full overwrites the
//                             oldest entry and sets overflow.
//                undefined -> bounded stack. A push when full is dropped and
//                             sets overflow.
//
// Ports:
//   clock      in   system clock, rising-edge active
//   reset      in   asynchronous active-high reset
//   rasWrite   in   update enable (driven with pcWrite); gates push/pop
//   push       in   call: store pushAddr as the new top
//   pop        in   return: discard the top entry
//   pushAddr   in   link address to push [ADDR_W]
//   clearErr   in   synchronous clear of the sticky error flags
//   ra         out  top-of-stack address, 0 when empty [ADDR_W]
//   count      out  number of valid entries, 0..DEPTH [PTR_W+1]
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  sticky: a push was lost or an entry was overwritten
//   underflow  out  sticky: a pop was attempted while empty
// ----------------------------------------------------------------------------
module ra_stack #(
   parameter int DEPTH  = 8,   // power of two, >= 2
   parameter int PTR_W  = 3,   // log2(DEPTH)
   parameter int ADDR_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rasWrite,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] pushAddr,
   input  logic              clearErr,
   output logic [ADDR_W-1:0] ra,
   output logic [PTR_W:0]    count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   // State registers
   logic [PTR_W-1:0]  top_q, top_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [ADDR_W-1:0] entry_q [DEPTH];

   // Entry-write request produced by the next-state logic
   logic              wr_en;
   logic [PTR_W-1:0]  wr_idx;

   // Outputs decode registered state only.
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_MAX);
   assign ra        = empty ? '0 : entry_q[top_q];
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

   // Next-state decode of the operation table.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path through
      // the case tree can leave it unassigned and infer a latch.
      top_d   = top_q;
      count_d = count_q;
      ovf_d   = ovf_q & ~clearErr;   // clear acts regardless of rasWrite;
      unf_d   = unf_q & ~clearErr;   // a same-cycle error event overrides it
      wr_en   = 1'b0;
      wr_idx  = top_q + PTR_ONE;

      // Reset gating keeps a pending entry write from landing during reset.
      if (rasWrite && !reset) begin
         if (push && pop && !empty) begin
            // Tail call: replace the top in place, no flag change even if full.
            wr_en  = 1'b1;
            wr_idx = top_q;
         end else if (push) begin
            // Also covers push+pop on an empty stack.
            if (!full) begin
               wr_en   = 1'b1;
               top_d   = top_q + PTR_ONE;
               count_d = count_q + CNT_ONE;
            end else begin
               ovf_d = 1'b1;
`ifdef RAS_WRAP_EN
               // Slot top+1 wraps onto the oldest entry; count stays at DEPTH.
               wr_en = 1'b1;
               top_d = top_q + PTR_ONE;
`endif
            end
         end else if (pop) begin
            if (!empty) begin
               top_d   = top_q - PTR_ONE;
               count_d = count_q - CNT_ONE;
            end else begin
               unf_d = 1'b1;
            end
         end
      end
   end

   // NOTE: non-blocking assignments for all clocked state so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         top_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // NOTE: entry storage has no reset; count gates validity, so stale contents
   // are never observable and the array can map onto plain flops or RAM.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         entry_q[wr_idx] <= pushAddr;
      end
   end

endmodule

// File: tb/tb_ra_stack.sv
// ----------------------------------------------------------------------------
// tb_ra_stack -- self-checking bench for ra_stack (DEPTH=8, ADDR_W=16).
// Expected outputs come from a queue-based stack model; each driven step
// pushes its expected snapshot to a scoreboard queue, which is popped and
// compared #1 after the sampling edge. Build with +define+RAS_WRAP_EN to
// exercise the circular-stack variant.
// ----------------------------------------------------------------------------
module tb_ra_stack;

   localparam int DEPTH  = 8;
   localparam int PTR_W  = 3;
   localparam int ADDR_W = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] ra;
      logic [PTR_W:0]    cnt;
      logic              emp;
      logic              ful;
      logic              ovf;
      logic              unf;
   } exp_t;

   logic              clock = 1'b0;
   logic              reset;
   logic              ras_write;
   logic              push_s;
   logic              pop_s;
   logic [ADDR_W-1:0] push_addr;
   logic              clear_err;
   logic [ADDR_W-1:0] ra_o;
   logic [PTR_W:0]    count_o;
   logic              empty_o;
   logic              full_o;
   logic              overflow_o;
   logic              underflow_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: back of the queue is top of stack.
   logic [ADDR_W-1:0] stk[$];
   logic              m_ovf;
   logic              m_unf;
   exp_t              exp_q[$];

   ra_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .ADDR_W(ADDR_W)) dut (
      .clock     (clock),
      .reset     (reset),
      .rasWrite  (ras_write),
      .push      (push_s),
      .pop       (pop_s),
      .pushAddr  (push_addr),
      .clearErr  (clear_err),
      .ra        (ra_o),
      .count     (count_o),
      .empty     (empty_o),
      .full      (full_o),
      .overflow  (overflow_o),
      .underflow (underflow_o)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model_snapshot();
      exp_t e;
      e.cnt = (PTR_W+1)'(stk.size());
      e.ra  = (stk.size() > 0) ? stk[$] : '0;
      e.emp = (stk.size() == 0);
      e.ful = (stk.size() == DEPTH);
      e.ovf = m_ovf;
      e.unf = m_unf;
      return e;
   endfunction

   task automatic model_reset();
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic model_step(input logic rw, input logic ps, input logic pp,
                             input logic [ADDR_W-1:0] a, input logic clr);
      logic ovf_ev = 1'b0;
      logic unf_ev = 1'b0;
      if (rw) begin
         if (ps && pp && stk.size() > 0) begin
            stk[stk.size()-1] = a;
         end else if (ps) begin
            if (stk.size() < DEPTH) begin
               stk.push_back(a);
            end else begin
               ovf_ev = 1'b1;
`ifdef RAS_WRAP_EN
               void'(stk.pop_front());
               stk.push_back(a);
`endif
            end
         end else if (pp) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else unf_ev = 1'b1;
         end
      end
      m_ovf = ovf_ev | (m_ovf & ~clr);
      m_unf = unf_ev | (m_unf & ~clr);
   endtask

   task automatic compare_outputs(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_ra"},        32'(ra_o),        32'(e.ra));
         check({tag, "_count"},     32'(count_o),     32'(e.cnt));
         check({tag, "_empty"},     32'(empty_o),     32'(e.emp));
         check({tag, "_full"},      32'(full_o),      32'(e.ful));
         check({tag, "_overflow"},  32'(overflow_o),  32'(e.ovf));
         check({tag, "_underflow"}, 32'(underflow_o), 32'(e.unf));
      end
   endtask

   // Called #1 after an edge: drive, predict, wait one edge, compare.
   task automatic step(input logic rw, input logic ps, input logic pp,
                       input logic [ADDR_W-1:0] a, input logic clr, input string tag);
      ras_write = rw;
      push_s    = ps;
      pop_s     = pp;
      push_addr = a;
      clear_err = clr;
      model_step(rw, ps, pp, a, clr);
      exp_q.push_back(model_snapshot());
      @(posedge clock);
      #1;
      compare_outputs(tag);
   endtask

   task automatic idle_inputs();
      ras_write = 1'b0;
      push_s    = 1'b0;
      pop_s     = 1'b0;
      push_addr = '0;
      clear_err = 1'b0;
   endtask

   initial begin
      logic rw, ps, pp, clr;
      logic [ADDR_W-1:0] a;

      // ---------------- reset ----------------
      idle_inputs();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      exp_q.push_back(model_snapshot());
      compare_outputs("reset");
      step(1, 0, 0, 16'h0000, 0, "idle_hold");
      step(1, 0, 0, 16'h0000, 0, "idle_hold2");

      // ---------------- basic push / pop ----------------
      step(1, 1, 0, 16'h0010, 0, "push1");
      check("push1_ra_lit", 32'(ra_o), 32'h0010);
      step(1, 1, 0, 16'h0020, 0, "push2");
      step(1, 1, 0, 16'h0030, 0, "push3");
      check("push3_ra_lit", 32'(ra_o), 32'h0030);
      check("push3_cnt_lit", 32'(count_o), 32'd3);
      step(1, 0, 1, 16'h0000, 0, "pop1");
      check("pop1_ra_lit", 32'(ra_o), 32'h0020);
      step(1, 0, 1, 16'h0000, 0, "pop2");
      step(1, 0, 1, 16'h0000, 0, "pop3");
      check("pop3_ra_lit", 32'(ra_o), 32'h0000);
      check("pop3_empty_lit", 32'(empty_o), 32'd1);

      // ---------------- async reset between edges ----------------
      step(1, 1, 0, 16'h0777, 0, "pre_async");
      idle_inputs();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      exp_q.push_back(model_snapshot());
      compare_outputs("async_reset");
      reset = 1'b0;
      @(posedge clock);
      #1;
      step(1, 0, 0, 16'h0000, 0, "post_async");

      // ---------------- rasWrite gating and tail call ----------------
      step(1, 1, 0, 16'h0100, 0, "push_0100");
      step(0, 1, 0, 16'h0200, 0, "gated1");
      step(0, 1, 0, 16'h0200, 0, "gated2");
      step(0, 1, 1, 16'h0200, 0, "gated3");
      check("gated_ra_lit", 32'(ra_o), 32'h0100);
      step(1, 1, 1, 16'h0300, 0, "tailcall");
      check("tailcall_ra_lit", 32'(ra_o), 32'h0300);
      check("tailcall_cnt_lit", 32'(count_o), 32'd1);
      step(1, 0, 1, 16'h0000, 0, "drain");
      step(1, 1, 1, 16'h0400, 0, "pushpop_empty");
      check("pushpop_empty_cnt_lit", 32'(count_o), 32'd1);
      step(1, 0, 1, 16'h0000, 0, "drain2");

      // ---------------- underflow and clearErr ----------------
      step(1, 0, 1, 16'h0000, 0, "underflow");
      check("underflow_lit", 32'(underflow_o), 32'd1);
      step(0, 0, 0, 16'h0000, 1, "clear_err");
      check("clear_err_lit", 32'(underflow_o), 32'd0);
      step(1, 0, 1, 16'h0000, 1, "pop_and_clear");
      check("pop_and_clear_lit", 32'(underflow_o), 32'd1);
      step(1, 0, 0, 16'h0000, 1, "clear_err2");

      // ---------------- fill to full and push past it ----------------
      for (int i = 1; i <= DEPTH; i++) begin
         step(1, 1, 0, ADDR_W'(2 * i), 0, $sformatf("fill%0d", i));
      end
      check("full_lit", 32'(full_o), 32'd1);
      check("full_ra_lit", 32'(ra_o), 32'h0010);
      step(1, 1, 0, 16'h0012, 0, "push_full");
`ifdef RAS_WRAP_EN
      check("push_full_ra_lit", 32'(ra_o), 32'h0012);
`else
      check("push_full_ra_lit", 32'(ra_o), 32'h0010);
`endif
      check("push_full_cnt_lit", 32'(count_o), 32'd8);
      check("push_full_ovf_lit", 32'(overflow_o), 32'd1);
      step(1, 1, 1, 16'h0014, 0, "tailcall_full");
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 1, 16'h0000, 0, $sformatf("unwind%0d", i));
      end
      step(1, 0, 0, 16'h0000, 1, "clear_err3");

      // ---------------- random against the model ----------------
      for (int i = 0; i < 600; i++) begin
         rw  = ($urandom_range(0, 3) != 0);
         // First half leans toward pushes so full/overflow get exercised.
         ps  = (i < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 1) == 1);
         pp  = ($urandom_range(0, 1) == 1);
         clr = ($urandom_range(0, 19) == 0);
         a   = ADDR_W'($urandom);
         step(rw, ps, pp, a, clr, $sformatf("rand%0d", i));
      end

      idle_inputs();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
